branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Execute-stage branch resolution unit. It is the producer side of the predictor-update and redirect interface that the fetch PC register consumes.
- Per accepted control-flow instruction it:
  - computes the real outcome and target;
  - compares the real next PC against the next PC predicted at fetch;
  - emits a registered predictor-training update and, on mismatch, a one-cycle redirect.
- After a redirect it squashes wrong-path instructions for a fixed window. It also keeps branch and mispredict performance counters.

Parameters:
- SQUASH_CYCLES, 2, cycles after a redirect during which ex_valid is ignored (wrong-path drain).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX holds a valid instruction
- stall_in  in  1  EX stage stalled; input is not accepted this cycle
- ex_kind  in  2  00 none, 01 cond branch, 10 jal, 11 jalr
- ex_funct3  in  3  branch condition code
- ex_pc  in  32  instruction PC
- ex_pred_pc  in  32  next PC chosen at fetch, carried down the pipe
- rs1_val  in  32  operand 1
- rs2_val  in  32  operand 2
- imm  in  32  sign-extended immediate
- branch_flag  out  1  predictor update valid (one-cycle pulse)
- branch_taken  out  1  real outcome of the updated instruction
- branch_pc  out  32  PC of the updated instruction
- btb_target  out  32  target to write into the BTB
- jump_flag  out  1  redirect pulse
- branch_to  out  32  redirect PC
- squash  out  1  high while in FLUSH; younger stages drop their contents
- branch_cnt  out  CNT_W  resolved branch/jump count
- miss_cnt  out  CNT_W  redirect count

Behaviour:
- Reset: all outputs are 0, the counters are 0, and the state machine is IDLE. A reset during FLUSH aborts the window immediately.
- Accept condition: ex_valid && !stall_in && ex_kind != 00 && state == IDLE.
- Condition by ex_funct3:
  - 000 eq
  - 001 ne
  - 100 signed lt
  - 101 signed ge
  - 110 unsigned lt
  - 111 unsigned ge
  - 010 and 011 are never taken
- Targets (32-bit modular arithmetic, wrap-around allowed):
  - cond branch and jal: ex_pc + imm
  - jalr: (rs1_val + imm) & ~1
- taken:
  - cond branch: the condition result
  - jal and jalr: always 1
- actual_next = taken ? target : ex_pc + 4.
- All outputs are registered, with a latency of 1 cycle from the accept edge.
- Training update:
  - branch_flag = 1 for kinds 01 and 10 only. jalr never trains the BTB.
  - branch_pc = ex_pc.
  - btb_target = ex_pc + imm, even when the branch is not taken.
  - branch_taken = taken.
- Redirect:
  - Condition: actual_next != ex_pred_pc (all kinds, including jalr).
  - On redirect: jump_flag = 1, branch_to = actual_next, miss_cnt + 1, state goes to FLUSH.
- branch_cnt increments on every accept. Both counters saturate at all-ones.
- Pulse timing:
  - branch_flag and jump_flag are high for exactly one cycle.
  - In any non-accept cycle they are 0.
  - branch_pc, btb_target and branch_to hold their last values.
- State machine:
  - IDLE: transitions to FLUSH on a redirect. The flush counter loads SQUASH_CYCLES.
  - FLUSH: squash = 1, ex_valid is ignored, and the counter decrements every cycle regardless of stall_in. At 0 the state returns to IDLE.
  - The cycle after returning to IDLE can accept.
- If SQUASH_CYCLES = 0, the block stays in IDLE and squash is never asserted.
- stall_in high while ex_valid is high: nothing is accepted and no pulse is produced. The same instruction is resolved exactly once, when the stall drops.
- ex_kind == 00: no update, no count.

Decomposition:
- Shared package/include:
  - ex_kind encodings
  - funct3 branch codes
  - the Zero constant
  - state encodings IDLE and FLUSH
- One natural sub-module: branch_cmp, a combinational condition evaluator (funct3, rs1, rs2 -> taken).
- The targets, the state machine and the counters stay in branch_resolve.

Test Plan:
- Mispredicted BEQ: pc=0x100, rs1=rs2=5, imm=0x20, pred=0x104 -> next cycle branch_flag=1, taken=1, btb_target=0x120, jump_flag=1, branch_to=0x120. squash is high for 2 cycles, and valid inputs during those cycles produce no pulses. miss_cnt=1.
- Correctly predicted BLT, not taken: rs1=-1, rs2=-2, pc=0x200, imm=0x40, pred=0x204 -> branch_flag=1, taken=0, btb_target=0x240, jump_flag=0, branch_cnt increments, miss_cnt is unchanged.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1. BLTU gives taken=0; BLT gives taken=1 (pred=pc+4, so jump_flag=1).
- JALR: rs1=0x1003, imm=0, pc=0x300, pred=0x304 -> branch_flag=0, jump_flag=1, branch_to=0x1002.
- Stall: valid JAL held for 3 cycles with stall_in=1, then released -> exactly one branch_flag pulse, and branch_cnt increments by 1.
- Reset during FLUSH: redirect, then rst for 1 cycle -> squash=0 and counters 0 the next cycle, and the next valid branch is accepted immediately.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolution unit:
// instruction kinds, branch condition codes and resolver states.
package branch_resolve_pkg;

   typedef enum logic [1:0] {
      KindNone   = 2'b00,
      KindBranch = 2'b01,
      KindJal    = 2'b10,
      KindJalr   = 2'b11
   } ex_kind_e;

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   localparam logic [31:0] Zero = 32'd0;

   typedef enum logic {
      StIdle  = 1'b0,
      StFlush = 1'b1
   } state_e;

endpackage

// File: rtl/branch_resolve_cmp.sv
// Combinational branch condition evaluator: funct3 and two operands in, taken out.
module branch_cmp
   import branch_resolve_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3Beq:   taken = (rs1 == rs2);
         F3Bne:   taken = (rs1 != rs2);
         F3Blt:   taken = ($signed(rs1) < $signed(rs2));
         F3Bge:   taken = ($signed(rs1) >= $signed(rs2));
         F3Bltu:  taken = (rs1 < rs2);
         F3Bgeu:  taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: predictor training, redirect on mispredict,
// wrong-path squash window and saturating branch/mispredict counters.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int unsigned SQUASH_CYCLES = 2,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic             stall_in,
   input  logic [1:0]       ex_kind,
   input  logic [2:0]       ex_funct3,
   input  logic [31:0]      ex_pc,
   input  logic [31:0]      ex_pred_pc,
   input  logic [31:0]      rs1_val,
   input  logic [31:0]      rs2_val,
   input  logic [31:0]      imm,
   output logic             branch_flag,
   output logic             branch_taken,
   output logic [31:0]      branch_pc,
   output logic [31:0]      btb_target,
   output logic             jump_flag,
   output logic [31:0]      branch_to,
   output logic             squash,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned FlushW = (SQUASH_CYCLES > 1) ? $clog2(SQUASH_CYCLES + 1) : 1;
   localparam logic [FlushW-1:0] FlushLoad = FlushW'(SQUASH_CYCLES);
   localparam logic [FlushW-1:0] FlushOne  = FlushW'(1);
   localparam logic [CNT_W-1:0]  CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q;
   logic [FlushW-1:0] flush_q;

   logic              cond_taken, taken, accept, trains, redirect;
   logic [31:0]       pc_target, jalr_target, target, actual_next;

   logic              branch_flag_q, branch_taken_q, jump_flag_q;
   logic [31:0]       branch_pc_q, btb_target_q, branch_to_q;
   logic [CNT_W-1:0]  branch_cnt_q, miss_cnt_q;

   branch_cmp u_cmp (
      .funct3 (ex_funct3),
      .rs1    (rs1_val),
      .rs2    (rs2_val),
      .taken  (cond_taken)
   );

   always_comb begin
      pc_target   = ex_pc + imm;
      jalr_target = (rs1_val + imm) & ~32'd1;
      target      = (ex_kind == KindJalr) ? jalr_target : pc_target;
      taken       = (ex_kind == KindBranch) ? cond_taken : 1'b1;
      actual_next = taken ? target : ex_pc + 32'd4;
      accept      = ex_valid && !stall_in && (ex_kind != KindNone) && (state_q == StIdle);
      // jalr targets are data-dependent, so they never train the BTB
      trains      = (ex_kind == KindBranch) || (ex_kind == KindJal);
      redirect    = accept && (actual_next != ex_pred_pc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_flag_q  <= 1'b0;
         branch_taken_q <= 1'b0;
         jump_flag_q    <= 1'b0;
         branch_pc_q    <= Zero;
         btb_target_q   <= Zero;
         branch_to_q    <= Zero;
         branch_cnt_q   <= '0;
         miss_cnt_q     <= '0;
      end else begin
         branch_flag_q <= accept && trains;
         jump_flag_q   <= redirect;
         if (accept && trains) begin
            branch_taken_q <= taken;
            branch_pc_q    <= ex_pc;
            btb_target_q   <= pc_target;
         end
         if (redirect) begin
            branch_to_q <= actual_next;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CntOne;
         end
         if (accept && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         flush_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (redirect && (SQUASH_CYCLES != 0)) begin
                  state_q <= StFlush;
                  flush_q <= FlushLoad;
               end
            end
            StFlush: begin
               flush_q <= flush_q - FlushOne;
               if (flush_q == FlushOne) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign branch_flag  = branch_flag_q;
   assign branch_taken = branch_taken_q;
   assign branch_pc    = branch_pc_q;
   assign btb_target   = btb_target_q;
   assign jump_flag    = jump_flag_q;
   assign branch_to    = branch_to_q;
   assign squash       = (state_q == StFlush);
   assign branch_cnt   = branch_cnt_q;
   assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the resolution rules.
module tb_branch_resolve;

   localparam int unsigned SQ = 2;
   localparam int unsigned CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid, stall_in;
   logic [1:0]    ex_kind;
   logic [2:0]    ex_funct3;
   logic [31:0]   ex_pc, ex_pred_pc, rs1_val, rs2_val, imm;
   logic          branch_flag, branch_taken, jump_flag, squash;
   logic [31:0]   branch_pc, btb_target, branch_to;
   logic [CW-1:0] branch_cnt, miss_cnt;

   branch_resolve #(.SQUASH_CYCLES(SQ), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_valid     (ex_valid),
      .stall_in     (stall_in),
      .ex_kind      (ex_kind),
      .ex_funct3    (ex_funct3),
      .ex_pc        (ex_pc),
      .ex_pred_pc   (ex_pred_pc),
      .rs1_val      (rs1_val),
      .rs2_val      (rs2_val),
      .imm          (imm),
      .branch_flag  (branch_flag),
      .branch_taken (branch_taken),
      .branch_pc    (branch_pc),
      .btb_target   (btb_target),
      .jump_flag    (jump_flag),
      .branch_to    (branch_to),
      .squash       (squash),
      .branch_cnt   (branch_cnt),
      .miss_cnt     (miss_cnt)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   int          flush_left;
   logic        m_bf, m_bt, m_jf;
   logic [31:0] m_bpc, m_btb, m_to;
   logic [31:0] m_bcnt, m_mcnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   function automatic bit cond_of(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
      int sa = a;
      int sb = b;
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return sa < sb;
         3'd5:    return sa >= sb;
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_edge();
      bit          acc, tk;
      logic [31:0] tgt, nxt;
      m_bf = 1'b0;
      m_jf = 1'b0;
      if (rst) begin
         flush_left = 0;
         m_bt = 0; m_bpc = 0; m_btb = 0; m_to = 0; m_bcnt = 0; m_mcnt = 0;
         return;
      end
      acc = ex_valid && !stall_in && (ex_kind != 2'd0) && (flush_left == 0);
      if (flush_left > 0) flush_left--;
      if (!acc) return;
      tk  = (ex_kind == 2'd1) ? cond_of(ex_funct3, rs1_val, rs2_val) : 1'b1;
      tgt = (ex_kind == 2'd3) ? ((rs1_val + imm) & 32'hFFFF_FFFE) : ex_pc + imm;
      nxt = tk ? tgt : ex_pc + 32'd4;
      if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
      if (ex_kind == 2'd1 || ex_kind == 2'd2) begin
         m_bf = 1'b1; m_bt = tk; m_bpc = ex_pc; m_btb = ex_pc + imm;
      end
      if (nxt != ex_pred_pc) begin
         m_jf = 1'b1;
         m_to = nxt;
         if (m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
         flush_left = SQ;
      end
   endtask

   task automatic check_all();
      chk("branch_flag", {31'd0, branch_flag}, {31'd0, m_bf});
      chk("branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
      chk("branch_pc", branch_pc, m_bpc);
      chk("btb_target", btb_target, m_btb);
      chk("jump_flag", {31'd0, jump_flag}, {31'd0, m_jf});
      chk("branch_to", branch_to, m_to);
      chk("squash", {31'd0, squash}, {31'd0, 1'(flush_left > 0)});
      chk("branch_cnt", branch_cnt, m_bcnt);
      chk("miss_cnt", miss_cnt, m_mcnt);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic st, input logic [1:0] k,
                        input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] pred,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
      ex_valid = v; stall_in = st; ex_kind = k; ex_funct3 = f3; ex_pc = pc;
      ex_pred_pc = pred; rs1_val = a; rs2_val = b; imm = im;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 4))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] cnt0;
      int          pulses;
      logic [31:0] pc, im;

      rst = 1'b1;
      drive(0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
      cycle();
      cycle();
      chk("reset_squash", {31'd0, squash}, 32'd0);
      chk("reset_bcnt", branch_cnt, 32'd0);
      rst = 1'b0;
      idle(1);

      // Mispredicted BEQ, then wrong-path instructions during the squash window
      drive(1, 0, 2'd1, 3'd0, 32'h100, 32'h104, 5, 5, 32'h20);
      cycle();
      chk("beq_flag", {31'd0, branch_flag}, 32'd1);
      chk("beq_taken", {31'd0, branch_taken}, 32'd1);
      chk("beq_btb", btb_target, 32'h120);
      chk("beq_jump", {31'd0, jump_flag}, 32'd1);
      chk("beq_to", branch_to, 32'h120);
      chk("beq_miss", miss_cnt, 32'd1);
      drive(1, 0, 2'd2, 3'd0, 32'h400, 32'h404, 0, 0, 32'h8);
      cycle();
      chk("flush1_squash", {31'd0, squash}, 32'd1);
      chk("flush1_flag", {31'd0, branch_flag | jump_flag}, 32'd0);
      cycle();
      chk("flush2_flag", {31'd0, branch_flag | jump_flag}, 32'd0);
      chk("flush_end", {31'd0, squash}, 32'd0);
      idle(1);

      // Correctly predicted, not-taken BLT
      cnt0 = branch_cnt;
      drive(1, 0, 2'd1, 3'd4, 32'h200, 32'h204, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h40);
      cycle();
      chk("blt_taken", {31'd0, branch_taken}, 32'd0);
      chk("blt_btb", btb_target, 32'h240);
      chk("blt_jump", {31'd0, jump_flag}, 32'd0);
      chk("blt_bcnt", branch_cnt, cnt0 + 1);
      chk("blt_miss", miss_cnt, 32'd1);

      // Signed vs unsigned compare
      drive(1, 0, 2'd1, 3'd6, 32'h500, 32'h504, 32'hFFFF_FFFF, 1, 32'h10);
      cycle();
      chk("bltu_taken", {31'd0, branch_taken}, 32'd0);
      drive(1, 0, 2'd1, 3'd4, 32'h500, 32'h504, 32'hFFFF_FFFF, 1, 32'h10);
      cycle();
      chk("blts_taken", {31'd0, branch_taken}, 32'd1);
      chk("blts_jump", {31'd0, jump_flag}, 32'd1);
      idle(2);

      // JALR redirect clears bit 0 and does not train
      drive(1, 0, 2'd3, 3'd0, 32'h300, 32'h304, 32'h1003, 0, 0);
      cycle();
      chk("jalr_flag", {31'd0, branch_flag}, 32'd0);
      chk("jalr_jump", {31'd0, jump_flag}, 32'd1);
      chk("jalr_to", branch_to, 32'h1002);
      idle(2);

      // Stalled JAL resolves exactly once
      cnt0   = branch_cnt;
      pulses = 0;
      drive(1, 1, 2'd2, 3'd0, 32'h600, 32'h610, 0, 0, 32'h10);
      for (int i = 0; i < 3; i++) begin
         cycle();
         pulses += int'(branch_flag);
      end
      stall_in = 1'b0;
      cycle();
      pulses += int'(branch_flag);
      idle(1);
      pulses += int'(branch_flag);
      chk("stall_pulses", pulses, 32'd1);
      chk("stall_bcnt", branch_cnt, cnt0 + 1);

      // Reset in the middle of a squash window
      drive(1, 0, 2'd2, 3'd0, 32'h700, 32'h704, 0, 0, 32'h40);
      cycle();
      chk("pre_rst_squash", {31'd0, squash}, 32'd1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst_squash", {31'd0, squash}, 32'd0);
      chk("rst_bcnt", branch_cnt, 32'd0);
      chk("rst_miss", miss_cnt, 32'd0);
      drive(1, 0, 2'd1, 3'd0, 32'h800, 32'h804, 1, 2, 32'h30);
      cycle();
      chk("post_rst_accept", {31'd0, branch_flag}, 32'd1);
      idle(1);

      // Random traffic against the model
      for (int i = 0; i < 500; i++) begin
         pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         im = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 511)) - 256);
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), pc, 0, pick_val(), pick_val(), im);
         case ($urandom_range(0, 2))
            0:       ex_pred_pc = pc + 32'd4;
            1:       ex_pred_pc = pc + im;
            default: ex_pred_pc = $urandom;
         endcase
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
